// File: rtl/matrix_pkg.sv
// Shared types and sizes for the 5x5 signed 8-bit matrix controllers.
package matrix_pkg;

  localparam int N_ELEM = 25;
  localparam int ELEM_W = 8;
  localparam int MAT_W  = N_ELEM * ELEM_W;
  localparam int CNT_W  = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    EXEC,
    OUT
  } ctrl_state_t;

  // Picks element idx out of a packed row-major matrix; indices past the
  // last element return zero so the select never reads outside the vector.
  function automatic logic [ELEM_W-1:0] get_elem(input logic [MAT_W-1:0] mat,
                                                 input logic [CNT_W-1:0] idx);
    logic [ELEM_W-1:0] elem;
    elem = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      if (idx == CNT_W'(i)) elem = mat[i*ELEM_W +: ELEM_W];
    end
    return elem;
  endfunction

endpackage

// File: rtl/matrix_sub_controller_if.sv
// Host byte stream, result stream and subtractor hookup for the
// matrix subtraction sequencer. slave is the controller side.
interface matrix_sub_controller_if;
  import matrix_pkg::*;

  logic              start;
  logic              abort;
  logic              in_valid;
  logic              in_ready;
  logic [ELEM_W-1:0] in_data;
  logic [MAT_W-1:0]  dp_a;
  logic [MAT_W-1:0]  dp_b;
  logic [MAT_W-1:0]  dp_result;
  logic              dp_overflow;
  logic              out_valid;
  logic              out_ready;
  logic [ELEM_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              overflow;
  logic              done;

  modport slave (
    input  start, abort, in_valid, in_data, dp_result, dp_overflow, out_ready,
    output in_ready, dp_a, dp_b, out_valid, out_data, out_last, busy, overflow, done
  );

  modport master (
    output start, abort, in_valid, in_data, dp_result, dp_overflow, out_ready,
    input  in_ready, dp_a, dp_b, out_valid, out_data, out_last, busy, overflow, done
  );

endinterface

// File: rtl/matrix_elem_counter.sv
// Element index counter shared by the load and output phases.
module matrix_elem_counter
  import matrix_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             at_last
);

  // Clear wins over increment so a phase change always restarts at element 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign at_last = (count == CNT_W'(N_ELEM - 1));

endmodule

// File: rtl/matrix_sub_controller.sv
// Sequencer for the 5x5 matrix subtractor: loads A then B from the byte
// stream, captures the difference in one execute cycle, streams it out.
module matrix_sub_controller
  import matrix_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  matrix_sub_controller_if.slave  bus
);

  ctrl_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic              at_last;
  logic              cnt_inc;
  logic              cnt_clr;
  logic              in_fire;
  logic              out_fire;

  logic [MAT_W-1:0]  dp_a_q;
  logic [MAT_W-1:0]  dp_b_q;
  logic [MAT_W-1:0]  result_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [ELEM_W-1:0] out_data_q;
  logic              out_last_q;
  logic              busy_q;
  logic              overflow_q;
  logic              done_q;

  matrix_elem_counter u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (cnt_inc),
    .clr     (cnt_clr),
    .count   (cnt),
    .at_last (at_last)
  );

  // Counter steering: advance on a beat, restart on every state change.
  always_comb begin
    in_fire  = in_ready_q & bus.in_valid;
    out_fire = out_valid_q & bus.out_ready;
    cnt_inc  = 1'b0;
    cnt_clr  = 1'b0;
    if (bus.abort) begin
      cnt_clr = 1'b1;
    end else begin
      case (state)
        IDLE:   cnt_clr = bus.start;
        LOAD_A, LOAD_B: begin
          if (in_fire) begin
            cnt_clr = at_last;
            cnt_inc = ~at_last;
          end
        end
        EXEC:   cnt_clr = 1'b1;
        OUT: begin
          if (out_fire) begin
            cnt_clr = at_last;
            cnt_inc = ~at_last;
          end
        end
        default: cnt_clr = 1'b1;
      endcase
    end
  end

  // Main sequencer with all handshake and status outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        state       <= IDLE;
        in_ready_q  <= 1'b0;
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
        out_last_q  <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              state      <= LOAD_A;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
              overflow_q <= 1'b0;
            end
          end
          LOAD_A: begin
            if (in_fire) begin
              for (int i = 0; i < N_ELEM; i++) begin
                if (cnt == CNT_W'(i)) dp_a_q[i*ELEM_W +: ELEM_W] <= bus.in_data;
              end
              if (at_last) state <= LOAD_B;
            end
          end
          LOAD_B: begin
            if (in_fire) begin
              for (int i = 0; i < N_ELEM; i++) begin
                if (cnt == CNT_W'(i)) dp_b_q[i*ELEM_W +: ELEM_W] <= bus.in_data;
              end
              if (at_last) begin
                state      <= EXEC;
                in_ready_q <= 1'b0;
              end
            end
          end
          EXEC: begin
            result_q    <= bus.dp_result;
            overflow_q  <= bus.dp_overflow;
            state       <= OUT;
            out_valid_q <= 1'b1;
            out_data_q  <= get_elem(bus.dp_result, '0);
            out_last_q  <= 1'b0;
          end
          OUT: begin
            if (out_fire) begin
              if (at_last) begin
                state       <= IDLE;
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
                out_last_q  <= 1'b0;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
              end else begin
                out_data_q <= get_elem(result_q, cnt + CNT_W'(1));
                out_last_q <= (cnt == CNT_W'(N_ELEM - 2));
              end
            end
          end
          default: begin
            state       <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.dp_a      = dp_a_q;
  assign bus.dp_b      = dp_b_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.overflow  = overflow_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_matrix_sub_controller.sv
// Directed bench for the matrix subtraction sequencer, with a behavioural
// subtractor standing in for the datapath instance.
module tb_matrix_sub_controller;
  import matrix_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [7:0] vecA [N_ELEM];
  logic [7:0] vecB [N_ELEM];
  logic [7:0] expR [N_ELEM];
  logic       expOvf;

  matrix_sub_controller_if bus ();

  matrix_sub_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural subtractor: wrapped 8-bit difference, OR of signed overflows.
  always_comb begin
    logic [7:0] ea, eb, ed;
    ea = '0;
    eb = '0;
    ed = '0;
    bus.dp_result   = '0;
    bus.dp_overflow = 1'b0;
    for (int i = 0; i < N_ELEM; i++) begin
      ea = bus.dp_a[i*8 +: 8];
      eb = bus.dp_b[i*8 +: 8];
      ed = ea - eb;
      bus.dp_result[i*8 +: 8] = ed;
      if ((ea[7] != eb[7]) && (ed[7] != ea[7])) bus.dp_overflow = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setVectors(input int kind);
    for (int i = 0; i < N_ELEM; i++) begin
      if (kind == 0) begin
        vecA[i] = 8'(i + 10);
        vecB[i] = 8'(i);
        expR[i] = 8'd10;
      end else begin
        vecA[i] = 8'h00;
        vecB[i] = 8'h00;
        expR[i] = 8'h00;
      end
    end
    if (kind == 0) begin
      expOvf = 1'b0;
    end else begin
      vecA[3] = 8'h7F;
      vecB[3] = 8'h80;
      expR[3] = 8'hFF;
      expOvf  = 1'b1;
    end
  endtask

  // One full operation; returns at the cycle done is seen (or after a reset
  // applied at rstAt), with the cycle count measured from the start edge.
  task automatic applyStimulus(input bit throttle, input bit pokeStart,
                               input int rstAt, output int doneCycle);
    int  cycle;
    int  inIdx;
    int  outIdx;
    bit  didReset;
    doneCycle = -1;
    inIdx     = 0;
    outIdx    = 0;
    didReset  = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cycle = 1;
    checkOutput("ovf_cleared_on_start", 32'(bus.overflow), 32'd0);
    checkOutput("busy_after_start", 32'(bus.busy), 32'd1);
    while (cycle < 2000) begin
      if (bus.done) begin
        doneCycle = cycle;
        break;
      end
      if (rstAt != 0 && cycle == rstAt) begin
        rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
        checkOutput("rst_out_last", 32'(bus.out_last), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("rst_dp_a_zero", 32'(bus.dp_a == '0), 32'd1);
        didReset = 1'b1;
        break;
      end
      if (inIdx < 2 * N_ELEM) begin
        bus.in_valid = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.in_data  = (inIdx < N_ELEM) ? vecA[inIdx] : vecB[inIdx-N_ELEM];
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.start     = pokeStart && (inIdx == 30);
      bus.out_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.out_valid) begin
        checkOutput("out_data", 32'(bus.out_data), (outIdx < N_ELEM) ? 32'(expR[outIdx]) : 32'hDEAD);
        checkOutput("out_last", 32'(bus.out_last), 32'(outIdx == N_ELEM - 1));
        if (bus.out_ready) outIdx++;
      end
      if (bus.in_ready && bus.in_valid) inIdx++;
      tick();
      cycle++;
    end
    bus.in_valid  = 1'b0;
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    if (didReset) begin
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
        if (bus.done) checkOutput("no_done_after_reset", 32'(bus.done), 32'd0);
        tick();
      end
      checkOutput("idle_after_reset", 32'(bus.busy), 32'd0);
    end else begin
      checkOutput("done_seen", 32'(doneCycle > 0), 32'd1);
      checkOutput("out_count", 32'(outIdx), 32'd25);
      checkOutput("overflow", 32'(bus.overflow), 32'(expOvf));
      checkOutput("busy_at_done", 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    int doneCycle;
    int beats;
    int guard;
    int doneCount;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state and idle behaviour
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_overflow", 32'(bus.overflow), 32'd0);
    checkOutput("reset_out_data", 32'(bus.out_data), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    repeat (3) tick();
    checkOutput("idle_no_accept", 32'(bus.in_ready), 32'd0);
    checkOutput("idle_dp_a_zero", 32'(bus.dp_a == '0), 32'd1);
    bus.in_valid = 1'b0;

    // start together with abort stays idle
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checkOutput("start_abort_idle", 32'(bus.busy), 32'd0);
    checkOutput("start_abort_in_ready", 32'(bus.in_ready), 32'd0);

    // Unthrottled A[i]=i+10, B[i]=i
    setVectors(0);
    applyStimulus(1'b0, 1'b0, 0, doneCycle);
    checkOutput("done_cycle", 32'(doneCycle), 32'd77);

    // start in the done cycle is accepted
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checkOutput("chain_start_busy", 32'(bus.busy), 32'd1);
    checkOutput("chain_start_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("done_one_cycle", 32'(bus.done), 32'd0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checkOutput("chain_abort_idle", 32'(bus.busy), 32'd0);

    // Overflow element and stickiness
    setVectors(1);
    applyStimulus(1'b0, 1'b0, 0, doneCycle);
    repeat (5) tick();
    checkOutput("overflow_sticky", 32'(bus.overflow), 32'd1);

    // Throttled run on the first vector set
    setVectors(0);
    applyStimulus(1'b1, 1'b0, 0, doneCycle);

    // Abort after 30 input beats
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    beats = 0;
    guard = 0;
    while (beats < 30 && guard < 200) begin
      bus.in_valid = 1'b1;
      bus.in_data  = (beats < N_ELEM) ? vecA[beats] : vecB[beats-N_ELEM];
      if (bus.in_ready) beats++;
      tick();
      guard++;
    end
    checkOutput("abort_beats_taken", 32'(beats), 32'd30);
    bus.in_valid = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_in_ready", 32'(bus.in_ready), 32'd0);
    doneCount = 0;
    for (int i = 0; i < 80; i++) begin
      if (bus.done) doneCount++;
      tick();
    end
    checkOutput("abort_no_done", 32'(doneCount), 32'd0);

    // Full run after abort, with a stray start during LOAD_B
    applyStimulus(1'b0, 1'b1, 0, doneCycle);
    checkOutput("poke_done_cycle", 32'(doneCycle), 32'd77);
    tick();

    // Reset in the middle of the output phase
    applyStimulus(1'b0, 1'b0, 60, doneCycle);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
